spi_cmd_bridge: RTL

- SPI slave front end that converts an external MCU's SPI transactions into the pipeline's byte command stream, and carries response bytes back out.
- Sits directly upstream of the pipeline top:
  - Its cmd_m_* output feeds the pipeline's command input (cmd_s_*).
  - Its cmd_s_* input consumes the pipeline's response output (cmd_m_*).
  - Its cmd_flush input is driven by the pipeline's cmd_reset.
- Fully synchronous to the system clock. SPI pins are oversampled, never used as clocks.

---
 rtl/spi_bridge_pkg.sv | 17 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/spi_cmd_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI command bridge.
// No logic; pure declarations.
// Imported by the bridge top and its FIFO.
package spi_bridge_pkg;

    typedef logic [7:0] byte_t;

    // {CPOL, CPHA} of the only supported SPI mode
    localparam logic [1:0] SPI_MODE0   = 2'b00;
    localparam int         SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with flush; head is presented from registered storage.
// Latency: a pushed byte is visible at data_out the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module byte_fifo
    import spi_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  push,
    input  byte_t data_in,
    input  logic  pop,
    output byte_t data_out,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    byte_t       mem_q [DEPTH];
    logic        pop_ok;
    logic        push_ok;

    // A pop on an empty FIFO is ignored; a full FIFO accepts a push only when a pop frees a slot
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_out = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointers; flush overrides any simultaneous push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_in;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_bridge.sv
// SPI mode-0 slave turning MCU frames into a byte command stream and shifting responses back out.
// Latency: received byte valid 4 clk after the clk edge that first registers the 8th SCLK high.
// Backpressure: cmd_s_ready = tx FIFO not full; rx bytes arriving into a full FIFO are dropped (rx_overflow).
module spi_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter int    RX_DEPTH     = 16,
    parameter int    TX_DEPTH     = 16,
    parameter byte_t TX_IDLE_BYTE = 8'h00
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  spi_sclk,
    input  logic  spi_cs_n,
    input  logic  spi_mosi,
    output logic  spi_miso,
    output logic  cmd_m_valid,
    input  logic  cmd_m_ready,
    output byte_t cmd_m_data,
    input  logic  cmd_s_valid,
    output logic  cmd_s_ready,
    input  byte_t cmd_s_data,
    input  logic  cmd_flush,
    output logic  rx_overflow
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_q, cs_n_q, mosi_q;
    logic       sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;

    spi_state_t state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_shift_q;     // the 8th bit comes straight from mosi_q at byte completion
    byte_t      tx_shift_q;
    logic       byte_done_q;
    logic       miso_q;
    logic       rx_push_q;
    byte_t      rx_push_dat_q;
    logic       overflow_q;
    logic       out_en_q;

    logic       rx_empty, rx_full, rx_pop;
    logic       tx_empty, tx_full, tx_push;
    byte_t      tx_head, tx_load_byte;
    logic       load_evt;

    assign spi_miso     = miso_q;
    assign cmd_m_valid  = !rx_empty;
    assign rx_pop       = cmd_m_valid && cmd_m_ready;
    assign cmd_s_ready  = out_en_q && !tx_full;
    assign tx_push      = cmd_s_valid && cmd_s_ready;
    assign rx_overflow  = overflow_q;
    assign tx_load_byte = tx_empty ? TX_IDLE_BYTE : tx_head;
    assign load_evt     = ((state_q == IDLE) && cs_fall_q) ||
                          ((state_q == SHIFT) && !cs_rise_q && sclk_fall_q && byte_done_q);

    // Synchronize SPI pins, then register once more to form aligned edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_q      <= sclk_sync_q[SYNC_STAGES-1];
            cs_n_q      <= cs_sync_q[SYNC_STAGES-1];
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <=  sclk_sync_q[SYNC_STAGES-1] && !sclk_q;
            sclk_fall_q <= !sclk_sync_q[SYNC_STAGES-1] &&  sclk_q;
            cs_fall_q   <= !cs_sync_q[SYNC_STAGES-1]   &&  cs_n_q;
            cs_rise_q   <=  cs_sync_q[SYNC_STAGES-1]   && !cs_n_q;
        end
    end

    // Frame state machine: shift rx on SCLK rise, shift/load tx on SCLK fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            byte_done_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_push_q     <= 1'b0;
            rx_push_dat_q <= '0;
        end else begin
            rx_push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall_q) begin
                        state_q     <= SHIFT;
                        bit_cnt_q   <= 3'd0;
                        byte_done_q <= 1'b0;
                        tx_shift_q  <= tx_load_byte;
                        miso_q      <= tx_load_byte[7];
                    end
                end
                SHIFT: begin
                    if (cs_rise_q) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= 3'd0;
                        byte_done_q <= 1'b0;
                        miso_q      <= 1'b0;
                    end else begin
                        if (sclk_rise_q) begin
                            rx_shift_q <= {rx_shift_q[5:0], mosi_q};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q   <= 1'b1;
                                rx_push_q     <= 1'b1;
                                rx_push_dat_q <= {rx_shift_q, mosi_q};
                            end
                        end
                        if (sclk_fall_q) begin
                            if (byte_done_q) begin
                                tx_shift_q  <= tx_load_byte;
                                miso_q      <= tx_load_byte[7];
                                byte_done_q <= 1'b0;
                            end else begin
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                                miso_q     <= tx_shift_q[6];
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a completed byte met a full rx FIFO with no pop to make room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (cmd_flush) begin
            overflow_q <= 1'b0;
        end else if (rx_push_q && rx_full && !rx_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Hold cmd_s_ready low until the first clk edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (cmd_flush),
        .push     (rx_push_q),
        .data_in  (rx_push_dat_q),
        .pop      (rx_pop),
        .data_out (cmd_m_data),
        .empty    (rx_empty),
        .full     (rx_full)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (cmd_flush),
        .push     (tx_push),
        .data_in  (cmd_s_data),
        .pop      (load_evt),
        .data_out (tx_head),
        .empty    (tx_empty),
        .full     (tx_full)
    );

endmodule
